// File: rtl/uart_tx_if.sv
// uart_tx_if: handshake between the register file (master) and the UART
// serial transmit engine (slave).
//   tx_p_data          byte to send, sampled on acceptance
//   uart_tx_data_valid level request, high while a byte is pending
//   par_en / par_typ   parity enable / type (0 even, 1 odd), sampled on acceptance
//   tx_out             serial line, idles high
//   busy               high while a frame is on the line
//   uart_tx_done       one-cycle pulse in the last cycle of the stop bit
interface uart_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_p_data;
  logic              uart_tx_data_valid;
  logic              par_en;
  logic              par_typ;
  logic              tx_out;
  logic              busy;
  logic              uart_tx_done;

  modport master (
    output tx_p_data, uart_tx_data_valid, par_en, par_typ,
    input  tx_out, busy, uart_tx_done
  );

  modport slave (
    input  tx_p_data, uart_tx_data_valid, par_en, par_typ,
    output tx_out, busy, uart_tx_done
  );
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: serial transmit engine. Accepts a byte from the register
// file when idle, then shifts out start, DATA_W data bits LSB-first,
// optional parity and one stop bit, each held CLKS_PER_BIT clocks.
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  uart_tx_if slave modport (data/valid/parity in; tx_out/busy/done out)
// All outputs are registered: the next-cycle output values are derived from
// the next state in the combinational process and captured with the state.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_W       = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shadow, shadow_n;
  logic              pen, pen_n;
  logic              ptyp, ptyp_n;
  logic              tx_q, tx_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      shadow <= '0;
      pen    <= 1'b0;
      ptyp   <= 1'b0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      shadow <= shadow_n;
      pen    <= pen_n;
      ptyp   <= ptyp_n;
      tx_q   <= tx_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    shadow_n = shadow;
    pen_n    = pen;
    ptyp_n   = ptyp;

    unique case (state)
      IDLE: begin
        if (bus.uart_tx_data_valid) begin
          shadow_n = bus.tx_p_data;
          pen_n    = bus.par_en;
          ptyp_n   = bus.par_typ;
          cnt_n    = '0;
          state_n  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          if (idx == IDX_LAST) state_n = pen ? PARITY : STOP;
          else                 idx_n   = idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Output values for the cycle after this edge, from the next state.
    tx_n = 1'b1;
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shadow_n[idx_n];
      PARITY:  tx_n = (^shadow_n) ^ ptyp_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
    // Done marks the final clock of the stop bit.
    done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
  end

  assign bus.tx_out       = tx_q;
  assign bus.busy         = busy_q;
  assign bus.uart_tx_done = done_q;
endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Serial transmit engine of the UART TX path, directly downstream of the register file.
- Consumes the parallel byte tx_p_data and the level request uart_tx_data_valid.
- Serialises the byte LSB-first with start, optional parity and stop bits on tx_out.
- Returns busy and a one-cycle uart_tx_done pulse, which the register file captures into its status register.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per serial bit (baud divisor). Legal range 2..65535.
- DATA_W, 8: payload width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_p_data  in  DATA_W  byte to send; sampled only on acceptance.
- uart_tx_data_valid  in  1  level request from the register file; high means a byte is pending.
- par_en  in  1  parity enable; sampled on acceptance.
- par_typ  in  1  parity type, 0 = even, 1 = odd; sampled on acceptance.
- tx_out  out  1  serial line; idles high.
- busy  out  1  high while a frame is on the line.
- uart_tx_done  out  1  one-cycle pulse in the last cycle of the stop bit.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst high at a rising edge forces state=IDLE and clears all counters.
  - Outputs after that edge: tx_out=1, busy=0, uart_tx_done=0.
  - Reset overrides every other input, including mid-frame. The line returns high on the next edge with no partial stop bit and no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If uart_tx_data_valid=1 at an edge: latch tx_p_data, par_en and par_typ into shadow registers, clear the baud counter, go to START.
  - From that edge, tx_out=0 and busy=1.
- Baud counter: counts 0..CLKS_PER_BIT-1. Each bit is held exactly CLKS_PER_BIT cycles, and state advances when the counter reaches CLKS_PER_BIT-1.
- START: tx_out=0 for one bit time, then go to DATA with bit index 0.
- DATA:
  - tx_out = shadow[bit index].
  - After each bit time the index increments.
  - After bit DATA_W-1, go to PARITY if the latched par_en=1, otherwise go to STOP.
- PARITY:
  - tx_out = XOR-reduce(shadow) XOR latched par_typ.
  - Even parity gives an even count of ones including the parity bit.
- STOP:
  - tx_out=1 for one bit time.
  - uart_tx_done=1 during exactly the final clk cycle of the stop bit.
  - Then go to IDLE; busy=0 from the next edge.
- Frame length: (1 + DATA_W + par_en + 1) * CLKS_PER_BIT cycles. busy is high for exactly that many cycles.
- Requests while busy:
  - uart_tx_data_valid is ignored in every state except IDLE.
  - Changes to tx_p_data, par_en or par_typ mid-frame do not affect the current frame.
- Back-to-back frames:
  - The register file drops uart_tx_data_valid on uart_tx_done.
  - If valid is still high in the first IDLE cycle, a new frame starts at that edge. The minimum gap is one idle-high cycle.
- No buffering: at most one frame is in flight.

Test Plan:
1. Reset dominance: rst=1 for 20 cycles with valid=1 and tx_p_data=8'hFF -> tx_out=1, busy=0, done=0 throughout.
2. Basic frame: CLKS_PER_BIT=4, par_en=0, send 8'hA5 -> tx_out bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high for 40 cycles; done high only in cycle 40.
3. Parity: 8'hA5 with par_en=1, par_typ=0 -> parity bit 0; with par_typ=1 -> parity bit 1; busy high for 44 cycles.
4. Request while busy: change tx_p_data to 8'h3C and toggle valid mid-frame -> frame still carries 8'hA5; exactly one done pulse.
5. Reset mid-frame: assert rst during DATA bit 3 -> next edge tx_out=1, busy=0, no done pulse; a following 8'h5A frame is transmitted correctly.
6. Back-to-back: hold valid high across done, with 8'h01 then 8'h80 -> second start bit begins one cycle after busy falls; both frames are bit-exact.
